// File: rtl/intersection_scheduler.sv
// Phase scheduler for a main/side road intersection with one pedestrian crossing.
// Main green is the resting phase. Side-road and pedestrian requests are latched and
// served after the main green minimum. When both are waiting, they are served in
// alternation. All phase timing advances only on the 'tick' enable.
module intersection_scheduler #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 32,
    parameter int YELLOW_T  = 3,
    parameter int WALK_T    = 6,
    parameter int ALLRED_T  = 1,
    parameter int CW        = 6
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       tick,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic [1:0] walk,
    output logic       ped_grant,
    output logic [2:0] phase
);

    localparam logic [2:0] MAIN_GRN = 3'd0;
    localparam logic [2:0] MAIN_YEL = 3'd1;
    localparam logic [2:0] ALLRED_A = 3'd2;
    localparam logic [2:0] SIDE_GRN = 3'd3;
    localparam logic [2:0] SIDE_YEL = 3'd4;
    localparam logic [2:0] WALK_ST  = 3'd5;
    localparam logic [2:0] WALK_FL  = 3'd6;
    localparam logic [2:0] ALLRED_B = 3'd7;

    localparam logic SRV_SIDE = 1'b0;
    localparam logic SRV_PED  = 1'b1;

    localparam logic [1:0] LT_RED = 2'd0;
    localparam logic [1:0] LT_YEL = 2'd1;
    localparam logic [1:0] LT_GRN = 2'd2;

    localparam logic [CW-1:0] GMIN_M1 = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_M1 = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YEL_M1  = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] WALK_M1 = CW'(WALK_T - 1);
    localparam logic [CW-1:0] AR_M1   = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] T_SAT   = {CW{1'b1}};

    logic [2:0]    state_r;
    logic [2:0]    next_state_s;
    logic [CW-1:0] timer_r;
    logic          side_pend_r;
    logic          ped_pend_r;
    logic          last_srv_r;
    logic          state_chg_s;
    logic [1:0]    main_light_s;
    logic [1:0]    side_light_s;
    logic [1:0]    walk_s;
    logic [1:0]    main_light_r;
    logic [1:0]    side_light_r;
    logic [1:0]    walk_r;
    logic          ped_grant_r;
    logic [2:0]    phase_r;

    // A phase of length D ends on the tick where the timer reads D-1.
    function automatic logic expire(input logic t, input logic [CW-1:0] cnt,
                                    input logic [CW-1:0] d_m1);
        return t && (cnt == d_m1);
    endfunction

    assign state_chg_s = (next_state_s != state_r);

    // Next-phase selection; transitions are only evaluated on tick.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            MAIN_GRN: begin
                if (tick && (timer_r >= GMIN_M1) && (side_pend_r || ped_pend_r)) begin
                    next_state_s = MAIN_YEL;
                end else begin
                    next_state_s = state_r;
                end
            end
            MAIN_YEL: begin
                if (expire(tick, timer_r, YEL_M1)) begin
                    next_state_s = ALLRED_A;
                end else begin
                    next_state_s = state_r;
                end
            end
            ALLRED_A: begin
                if (expire(tick, timer_r, AR_M1)) begin
                    if (side_pend_r && !ped_pend_r) begin
                        next_state_s = SIDE_GRN;
                    end else if (!side_pend_r && ped_pend_r) begin
                        next_state_s = WALK_ST;
                    end else if (side_pend_r && ped_pend_r) begin
                        next_state_s = (last_srv_r == SRV_SIDE) ? WALK_ST : SIDE_GRN;
                    end else begin
                        next_state_s = ALLRED_B;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            SIDE_GRN: begin
                if (tick && (((timer_r >= GMIN_M1) && !side_req) || (timer_r == GMAX_M1))) begin
                    next_state_s = SIDE_YEL;
                end else begin
                    next_state_s = state_r;
                end
            end
            SIDE_YEL: begin
                if (expire(tick, timer_r, YEL_M1)) begin
                    next_state_s = ALLRED_B;
                end else begin
                    next_state_s = state_r;
                end
            end
            WALK_ST: begin
                if (expire(tick, timer_r, WALK_M1)) begin
                    next_state_s = WALK_FL;
                end else begin
                    next_state_s = state_r;
                end
            end
            WALK_FL: begin
                if (expire(tick, timer_r, YEL_M1)) begin
                    next_state_s = ALLRED_B;
                end else begin
                    next_state_s = state_r;
                end
            end
            ALLRED_B: begin
                if (expire(tick, timer_r, AR_M1)) begin
                    next_state_s = MAIN_GRN;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = MAIN_GRN;
        endcase
    end

    // Light decode of the upcoming phase, so the registered lights track the state register.
    always_comb begin
        main_light_s = LT_RED;
        side_light_s = LT_RED;
        walk_s       = LT_RED;
        case (next_state_s)
            MAIN_GRN: main_light_s = LT_GRN;
            MAIN_YEL: main_light_s = LT_YEL;
            SIDE_GRN: side_light_s = LT_GRN;
            SIDE_YEL: side_light_s = LT_YEL;
            WALK_ST:  walk_s       = LT_GRN;
            WALK_FL:  walk_s       = LT_YEL;
            default:  main_light_s = LT_RED;
        endcase
    end

    // Phase register and phase timer (restarts on every phase change, saturates).
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= MAIN_GRN;
            timer_r <= {CW{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (state_chg_s) begin
                timer_r <= {CW{1'b0}};
            end else if (tick && (timer_r != T_SAT)) begin
                timer_r <= timer_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    // Request latches and round-robin memory; clearing on service entry beats a new request.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            side_pend_r <= 1'b0;
            ped_pend_r  <= 1'b0;
            last_srv_r  <= SRV_PED;
        end else begin
            if (state_chg_s && (next_state_s == SIDE_GRN)) begin
                side_pend_r <= 1'b0;
                last_srv_r  <= SRV_SIDE;
            end else if (side_req && (state_r != SIDE_GRN)) begin
                side_pend_r <= 1'b1;
            end else begin
                side_pend_r <= side_pend_r;
            end
            if (state_chg_s && (next_state_s == WALK_ST)) begin
                ped_pend_r <= 1'b0;
                last_srv_r <= SRV_PED;
            end else if (ped_req && (state_r != WALK_ST)) begin
                ped_pend_r <= 1'b1;
            end else begin
                ped_pend_r <= ped_pend_r;
            end
        end
    end

    // Registered outputs, updated in the same edge as the phase register.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            main_light_r <= LT_GRN;
            side_light_r <= LT_RED;
            walk_r       <= LT_RED;
            ped_grant_r  <= 1'b0;
            phase_r      <= MAIN_GRN;
        end else begin
            main_light_r <= main_light_s;
            side_light_r <= side_light_s;
            walk_r       <= walk_s;
            ped_grant_r  <= state_chg_s && (next_state_s == WALK_ST);
            phase_r      <= next_state_s;
        end
    end

    assign main_light = main_light_r;
    assign side_light = side_light_r;
    assign walk       = walk_r;
    assign ped_grant  = ped_grant_r;
    assign phase      = phase_r;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: each test queues its expected phase
// entries (phase, cycle); a monitor pops one per observed phase change and compares.
module tb_intersection_scheduler;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       tick = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] main_light;
    logic [1:0] side_light;
    logic [1:0] walk;
    logic       ped_grant;
    logic [2:0] phase;

    typedef struct {
        logic [2:0] ph;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   tick_div = 1;

    intersection_scheduler dut (
        .clock(clock), .clear(clear), .tick(tick), .side_req(side_req), .ped_req(ped_req),
        .main_light(main_light), .side_light(side_light), .walk(walk),
        .ped_grant(ped_grant), .phase(phase)
    );

    always #5 clock = ~clock;

    // Cycle index relative to the release of clear.
    always @(posedge clock) cyc <= clear ? 0 : cyc + 1;

    function automatic logic [5:0] lights_of(input logic [2:0] ph);
        case (ph)
            3'd0:    return 6'b10_00_00;
            3'd1:    return 6'b01_00_00;
            3'd3:    return 6'b00_10_00;
            3'd4:    return 6'b00_01_00;
            3'd5:    return 6'b00_00_10;
            3'd6:    return 6'b00_00_01;
            default: return 6'b00_00_00;
        endcase
    endfunction

    task automatic push(input logic [2:0] ph, input int c);
        exp_t e;
        e.ph  = ph;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        tick = (tick_div == 1) || ((cyc % tick_div) == (tick_div - 1));
    endtask

    task automatic run_to(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            step();
            guard++;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (main_light !== 2'd2 || side_light !== 2'd0 || walk !== 2'd0 ||
            ped_grant !== 1'b0 || phase !== 3'd0) begin
            errors++;
            $display("FAIL %s: got main=%0d side=%0d walk=%0d grant=%0d phase=%0d, want 2 0 0 0 0",
                     name, main_light, side_light, walk, ped_grant, phase);
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected phase entries never observed, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        clear = 1'b1;
        side_req = 1'b0;
        ped_req = 1'b0;
        #1;
        check_reset_outputs("reset_outputs");
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        tick = (tick_div == 1);
    endtask

    // Monitor: safety invariant and grant pulse every cycle; scoreboard pop on phase change.
    initial begin
        logic [2:0] prev_ph;
        logic [5:0] lt;
        int nz;
        exp_t e;
        prev_ph = 3'd0;
        forever begin
            @(negedge clock);
            if (clear) begin
                prev_ph = phase;
            end else begin
                nz = int'(main_light != 2'd0) + int'(side_light != 2'd0) + int'(walk != 2'd0);
                checks++;
                if (nz > 1) begin
                    errors++;
                    $display("FAIL safety cyc=%0d: main=%0d side=%0d walk=%0d, want at most one non-red",
                             cyc, main_light, side_light, walk);
                end
                if (phase != prev_ph) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_transition cyc=%0d: phase %0d->%0d, want no change",
                                 cyc, prev_ph, phase);
                    end else begin
                        e = exp_q.pop_front();
                        lt = lights_of(e.ph);
                        if (phase !== e.ph || cyc != e.cyc || {main_light, side_light, walk} !== lt ||
                            ped_grant !== (e.ph == 3'd5)) begin
                            errors++;
                            $display("FAIL transition: got phase=%0d cyc=%0d lights=%b grant=%0d, want phase=%0d cyc=%0d lights=%b grant=%0d",
                                     phase, cyc, {main_light, side_light, walk}, ped_grant,
                                     e.ph, e.cyc, lt, (e.ph == 3'd5));
                        end
                    end
                end else begin
                    checks++;
                    if (ped_grant !== 1'b0) begin
                        errors++;
                        $display("FAIL grant_hold cyc=%0d: ped_grant=%0d outside WALK entry, want 0", cyc, ped_grant);
                    end
                end
                prev_ph = phase;
            end
        end
    end

    // Directed stimulus.
    initial begin
        // 1: idle, no requests
        tick_div = 1;
        do_reset();
        run_to(100);
        #4;
        check_reset_outputs("idle_100");
        check_queue_empty("idle_queue");

        // 2: side request, released at cycle 15
        do_reset();
        side_req = 1'b1;
        push(3'd1, 8); push(3'd2, 11); push(3'd3, 12);
        push(3'd4, 20); push(3'd7, 23); push(3'd0, 24);
        run_to(15);
        side_req = 1'b0;
        run_to(45);
        check_queue_empty("side_queue");

        // 3: pedestrian pulse at cycle 2
        do_reset();
        push(3'd1, 8); push(3'd2, 11); push(3'd5, 12);
        push(3'd6, 18); push(3'd7, 21); push(3'd0, 22);
        run_to(2);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        run_to(45);
        check_queue_empty("ped_queue");

        // 4: both held; side, ped, side
        do_reset();
        side_req = 1'b1;
        ped_req = 1'b1;
        push(3'd1, 8);  push(3'd2, 11); push(3'd3, 12); push(3'd4, 44); push(3'd7, 47);
        push(3'd0, 48); push(3'd1, 56); push(3'd2, 59); push(3'd5, 60); push(3'd6, 66);
        push(3'd7, 69); push(3'd0, 70); push(3'd1, 78); push(3'd2, 81); push(3'd3, 82);
        run_to(85);
        check_queue_empty("rr_queue");

        // 5: side held, green capped at 32 ticks, then served again
        do_reset();
        side_req = 1'b1;
        push(3'd1, 8);  push(3'd2, 11); push(3'd3, 12); push(3'd4, 44); push(3'd7, 47);
        push(3'd0, 48); push(3'd1, 56); push(3'd2, 59); push(3'd3, 60);
        run_to(62);
        check_queue_empty("cap_queue");

        // 6: tick every 4th cycle, clear during side green
        tick_div = 4;
        do_reset();
        side_req = 1'b1;
        push(3'd1, 32); push(3'd2, 44); push(3'd3, 48);
        run_to(52);
        clear = 1'b1;
        #1;
        check_reset_outputs("mid_clear");
        check_queue_empty("slow_queue");
        tick_div = 1;
        do_reset();
        run_to(20);
        check_queue_empty("after_clear_queue");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
